// File: rtl/apb_resp_pkg.sv
// Shared types and helpers for the APB memory responder.
// Holds the FSM state enum, the data width and the address checker.
package apb_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  localparam int APB_DATA_W = 32;

  // Legal when word aligned and no bit above the word-index field is set.
  function automatic logic addr_ok(
    input logic [63:0] paddr,
    input int unsigned depth
  );
    int unsigned iw;
    iw = $clog2(depth);
    return (paddr[1:0] == 2'b00) && ((paddr >> (iw + 2)) == 64'd0);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter for the APB responder access phase.
// Ports: clk, reset, clr (zero), en (count), done (count == WAIT_CYCLES).
module apb_wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [2:0] cnt;

  assign done = (cnt == 3'(WAIT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer fronting a word-addressed register memory.
// Ports: clk, reset, APB psel/penable/pwrite/paddr/pwdata in;
// pready/prdata/pslverr out, plus sticky protocol_err_o.
module apb_mem_responder
  import apb_resp_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_W-1:0]     paddr_i,
  input  logic [APB_DATA_W-1:0] pwdata_i,
  output logic                  pready_o,
  output logic [APB_DATA_W-1:0] prdata_o,
  output logic                  pslverr_o,
  output logic                  protocol_err_o
);

  localparam int IW = $clog2(DEPTH);

  state_t                state;
  logic [APB_DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0]         idx;
  logic                  in_acc;
  logic                  active;
  logic                  done;
  logic                  ready;
  logic                  ok;

  // ST_SETUP marks the first penable cycle (the setup phase itself is
  // seen while idle), so a zero-wait transfer completes in ST_SETUP.
  assign in_acc = (state == ST_SETUP) || (state == ST_ACCESS);
  assign active = in_acc && psel_i && penable_i;
  assign ready  = active && done;

  assign idx = paddr_i[IW+1:2];
  assign ok  = addr_ok(64'(paddr_i), DEPTH);

  assign pready_o  = ready;
  assign pslverr_o = ready && !ok;
  assign prdata_o  = (ready && !pwrite_i && ok) ? mem[idx] : '0;

  apb_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .clr  (!active || ready),
    .en   (active),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      protocol_err_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (psel_i && penable_i) begin
            protocol_err_o <= 1'b1;
          end else if (psel_i) begin
            state <= ST_SETUP;
          end
        end
        ST_SETUP, ST_ACCESS: begin
          if (!active) begin
            protocol_err_o <= 1'b1;
            state          <= ST_IDLE;
          end else if (done) begin
            state <= ST_IDLE;
            if (pwrite_i && ok) begin
              mem[idx] <= pwdata_i;
            end
          end else begin
            state <= ST_ACCESS;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Self-checking bench for apb_mem_responder.
// Three instances (1, 0 and 3 wait states) against a behavioural model.
module tb_apb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        pslverr [3];
  logic        perr    [3];

  int          wc [3] = '{1, 0, 3};
  logic [31:0] mem_m [3][16];
  bit          perr_m [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_mem_responder #(
      .DEPTH      (16),
      .ADDR_W     (32),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .psel_i        (psel[g]),
      .penable_i     (penable),
      .pwrite_i      (pwrite),
      .paddr_i       (paddr),
      .pwdata_i      (pwdata),
      .pready_o      (pready[g]),
      .prdata_o      (prdata[g]),
      .pslverr_o     (pslverr[g]),
      .protocol_err_o(perr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit model_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd64);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      perr_m[d] = 1'b0;
      for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge
  // with psel low, so consecutive calls are back-to-back transfers.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd);
    int   n;
    bit   seen;
    bit   ok;
    logic [31:0] exp_rd;
    ok      = model_ok(a);
    exp_rd  = (!wr && ok) ? mem_m[d][a[5:2]] : 32'd0;
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    psel[d] = 1'b1;
    penable = 1'b0;
    @(negedge clk);
    check($sformatf("setup_rdy%0d", d), 32'(pready[d]), 0);
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 0;
    n = 0;
    while (!seen && n <= wc[d] + 2) begin
      @(negedge clk);
      if (pready[d]) seen = 1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    check($sformatf("ready_seen%0d", d), 32'(seen), 1);
    if (seen) begin
      check($sformatf("latency%0d", d), n, wc[d]);
      check($sformatf("slverr%0d", d), 32'(pslverr[d]), 32'(!ok));
      check($sformatf("rdata%0d@%h", d, a), prdata[d], exp_rd);
    end
    @(posedge clk); #1;
    if (seen && ok && wr) mem_m[d][a[5:2]] = wd;
    psel[d] = 1'b0;
    penable = 1'b0;
    check($sformatf("perr%0d", d), 32'(perr[d]), 32'(perr_m[d]));
  endtask

  task automatic idle_violation(input int d);
    psel[d] = 1'b1;
    penable = 1'b1;
    @(negedge clk);
    check("viol_rdy", 32'(pready[d]), 0);
    @(posedge clk); #1;
    psel[d]   = 1'b0;
    penable   = 1'b0;
    perr_m[d] = 1'b1;
    check("viol_perr", 32'(perr[d]), 1);
  endtask

  task automatic abort_write(input int d, input logic [31:0] a,
                             input logic [31:0] wd);
    paddr   = a;
    pwrite  = 1'b1;
    pwdata  = wd;
    psel[d] = 1'b1;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_rdy0", 32'(pready[d]), 0);
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("abort_rdy1", 32'(pready[d]), 0);
    @(posedge clk); #1;
    perr_m[d] = 1'b1;
    check("abort_perr", 32'(perr[d]), 1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    int r;
    w = 32'($urandom_range(0, 15)) << 2;
    r = $urandom_range(0, 9);
    if (r == 7) return w + 32'($urandom_range(1, 3));
    if (r == 8) return w + 32'h40;
    if (r == 9) return w | 32'h1000_0000;
    return w;
  endfunction

  initial begin
    reset   = 1'b1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_rdy%0d", d), 32'(pready[d]), 0);
      check($sformatf("rst_rd%0d", d), prdata[d], 0);
      check($sformatf("rst_err%0d", d), 32'(pslverr[d]), 0);
      check($sformatf("rst_perr%0d", d), 32'(perr[d]), 0);
    end
    @(posedge clk); #1;

    xfer(0, 1, 32'h08, 32'hDEAD_BEEF);
    xfer(0, 0, 32'h08, 32'h0);
    xfer(0, 0, 32'h02, 32'h0);
    xfer(0, 0, 32'h40, 32'h0);
    xfer(0, 0, 32'h00, 32'h0);

    xfer(1, 1, 32'h00, 32'h11);
    xfer(1, 1, 32'h04, 32'h22);
    xfer(1, 0, 32'h00, 32'h0);
    xfer(1, 0, 32'h04, 32'h0);

    idle_violation(0);
    xfer(0, 0, 32'h08, 32'h0);

    abort_write(2, 32'h0C, 32'h55);
    xfer(2, 0, 32'h0C, 32'h0);

    for (int i = 0; i < 80; i++) begin
      xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), rand_addr(),
           $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    xfer(0, 1, 32'h04, 32'hA5A5_A5A5);
    paddr   = 32'h04;
    pwrite  = 1'b1;
    pwdata  = 32'h5A5A_5A5A;
    psel[0] = 1'b1;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b1;
    psel    = '0;
    penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_perr0", 32'(perr[0]), 0);
    check("post_rst_perr2", 32'(perr[2]), 0);
    @(posedge clk); #1;
    xfer(0, 0, 32'h04, 32'h0);
    xfer(1, 0, 32'h04, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
